// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the 6502 core front end.
//   - T-state index constants T0_IDX..T5_IDX
//   - OPC_BRK opcode value
//   - tstate_t: one-hot cycle-timing state (bit k set means Tk)
package cpu_pkg;

  localparam int T0_IDX = 0;
  localparam int T1_IDX = 1;
  localparam int T2_IDX = 2;
  localparam int T3_IDX = 3;
  localparam int T4_IDX = 4;
  localparam int T5_IDX = 5;

  localparam logic [7:0] OPC_BRK = 8'h00;

  typedef enum logic [5:0] {
    TS_T0 = 6'b000001,
    TS_T1 = 6'b000010,
    TS_T2 = 6'b000100,
    TS_T3 = 6'b001000,
    TS_T4 = 6'b010000,
    TS_T5 = 6'b100000
  } tstate_t;

endpackage

// File: rtl/tstate_seq.sv
// tstate_seq: one-hot T-state register and next-state logic.
// Ports:
//   clk     in   core clock
//   reset   in   synchronous active-high reset, forces T2 (start of BRK run)
//   rdy     in   1 = advance, 0 = hold state
//   t0_req  in   request that the next cycle be T0 (honoured in T2..T4 only)
//   state   out  current one-hot T-state
module tstate_seq
  import cpu_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    rdy,
  input  logic    t0_req,
  output tstate_t state
);

  tstate_t state_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= TS_T2;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (rdy) begin
      unique case (state)
        TS_T0:   state_nxt = TS_T1;
        TS_T1:   state_nxt = TS_T2;
        TS_T2:   state_nxt = t0_req ? TS_T0 : TS_T3;
        TS_T3:   state_nxt = t0_req ? TS_T0 : TS_T4;
        TS_T4:   state_nxt = t0_req ? TS_T0 : TS_T5;
        // T5 is the longest possible instruction; always wrap to T0.
        TS_T5:   state_nxt = TS_T0;
        // A corrupted one-hot code ends the instruction so fetch resyncs.
        default: state_nxt = TS_T0;
      endcase
    end
  end

endmodule

// File: rtl/ir_timing_gen.sv
// ir_timing_gen: instruction register and cycle-timing sequencer feeding
// the decode PLA.
// Build option: IR_INT_INJECT_EN -- when defined, a pending interrupt at the
// opcode load edge replaces the fetched byte with BRK and pulses int_ack.
// Ports:
//   clk          in   core clock
//   reset        in   synchronous active-high reset (state T2, ir RESET_OPCODE)
//   rdy          in   1 = advance, 0 = hold IR and timing
//   db           in   data bus, latched as opcode at the end of T1
//   t0_req       in   next cycle is T0 (sampled in T2..T4)
//   int_pending  in   interrupt pending (IR_INT_INJECT_EN only)
//   int_ack      out  one-cycle pulse after an injected BRK (IR_INT_INJECT_EN only)
//   ir           out  instruction register
//   t_n          out  active-low one-hot timing, bit k low means Tk
//   sync         out  high during T1
module ir_timing_gen
  import cpu_pkg::*;
#(
  parameter logic [7:0] RESET_OPCODE = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rdy,
  input  logic [7:0] db,
  input  logic       t0_req,
`ifdef IR_INT_INJECT_EN
  input  logic       int_pending,
  output logic       int_ack,
`endif
  output logic [7:0] ir,
  output logic [5:0] t_n,
  output logic       sync
);

  tstate_t state;
  logic    ir_load;

  tstate_seq u_tstate_seq (
    .clk    (clk),
    .reset  (reset),
    .rdy    (rdy),
    .t0_req (t0_req),
    .state  (state)
  );

  // The opcode is captured on the edge that leaves T1; during T1 itself ir
  // still holds the previous opcode so the PLA can finish that instruction.
  assign ir_load = rdy && state[T1_IDX];

`ifdef IR_INT_INJECT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      ir      <= RESET_OPCODE;
      int_ack <= 1'b0;
    end else begin
      int_ack <= ir_load && int_pending;
      if (ir_load) begin
        ir <= int_pending ? OPC_BRK : db;
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      ir <= RESET_OPCODE;
    end else if (ir_load) begin
      ir <= db;
    end
  end
`endif

  assign t_n  = ~state;
  assign sync = state[T1_IDX];

endmodule

// File: tb/tb_ir_timing_gen.sv
module tb_ir_timing_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       rdy;
  logic [7:0] db;
  logic       t0_req;
  logic [7:0] ir;
  logic [5:0] t_n;
  logic       sync;
`ifdef IR_INT_INJECT_EN
  logic       int_pending;
  logic       int_ack;
`endif

  int total = 0;
  int bad   = 0;

  // reference model: current T index and IR contents
  int         m_st;
  logic [7:0] m_ir;
  logic       m_ack;
  bit         m_valid = 0;

  ir_timing_gen dut (
    .clk         (clk),
    .reset       (reset),
    .rdy         (rdy),
    .db          (db),
    .t0_req      (t0_req),
`ifdef IR_INT_INJECT_EN
    .int_pending (int_pending),
    .int_ack     (int_ack),
`endif
    .ir          (ir),
    .t_n         (t_n),
    .sync        (sync)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // advance the model by one edge using the inputs present at that edge
  task automatic model_edge();
    logic inj;
    inj = 1'b0;
`ifdef IR_INT_INJECT_EN
    inj = int_pending;
`endif
    if (reset) begin
      m_st = 2; m_ir = 8'h00; m_ack = 1'b0;
    end else begin
      m_ack = 1'b0;
      if (rdy) begin
        if (m_st == 1) begin
          m_ir  = inj ? 8'h00 : db;
          m_ack = inj;
        end
        case (m_st)
          0: m_st = 1;
          1: m_st = 2;
          5: m_st = 0;
          default: m_st = t0_req ? 0 : m_st + 1;
        endcase
      end
    end
    m_valid = 1;
  endtask

  // one clock: model follows the edge, all outputs compared on the falling edge
  task automatic step();
    logic [5:0] exp_tn;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    exp_tn = ~(6'b000001 << m_st);
    chk("t_n", {2'b00, t_n}, {2'b00, exp_tn});
    chk("sync", {7'd0, sync}, {7'd0, (m_st == 1)});
    chk("ir", ir, m_ir);
`ifdef IR_INT_INJECT_EN
    chk("int_ack", {7'd0, int_ack}, {7'd0, m_ack});
`endif
  endtask

  initial begin
    reset = 1'b1; rdy = 1'b0; db = 8'h5C; t0_req = 1'b1;
`ifdef IR_INT_INJECT_EN
    int_pending = 1'b0;
`endif
    @(negedge clk);
    step();
    chk("rst_tn", {2'b00, t_n}, 8'h3B);
    chk("rst_sync", {7'd0, sync}, 8'h00);
    chk("rst_ir", ir, 8'h00);

    // free run from reset: T3, T4, T5, T0, T1
    reset = 1'b0; rdy = 1'b1; t0_req = 1'b0; db = 8'h00;
    step(); chk("seq_t3", {2'b00, t_n}, 8'h37);
    step(); chk("seq_t4", {2'b00, t_n}, 8'h2F);
    step(); chk("seq_t5", {2'b00, t_n}, 8'h1F);
    step(); chk("seq_t0", {2'b00, t_n}, 8'h3E);
    step(); chk("seq_t1", {2'b00, t_n}, 8'h3D);
    chk("seq_sync", {7'd0, sync}, 8'h01);
    chk("seq_ir", ir, 8'h00);

    // load A9 in T1, short instruction via t0_req in T2
    db = 8'hA9;
    step(); chk("lda_ir", ir, 8'hA9);
    chk("lda_t2", {2'b00, t_n}, 8'h3B);
    db = 8'h00; t0_req = 1'b1;
    step(); chk("lda_t0", {2'b00, t_n}, 8'h3E);
    t0_req = 1'b0;
    step(); chk("lda_sync", {7'd0, sync}, 8'h01);

    // rdy stall in T3
    db = 8'h4C;
    step(); step();
    chk("stall_pre", {2'b00, t_n}, 8'h37);
    rdy = 1'b0; t0_req = 1'b1; db = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      step(); chk("stall_tn", {2'b00, t_n}, 8'h37);
      chk("stall_ir", ir, 8'h4C);
    end
    rdy = 1'b1; t0_req = 1'b0;
    step(); chk("stall_t4", {2'b00, t_n}, 8'h2F);

    // reset mid-instruction
    reset = 1'b1;
    step(); chk("mid_rst_tn", {2'b00, t_n}, 8'h3B);
    chk("mid_rst_ir", ir, 8'h00);
    reset = 1'b0;

    // t0_req ignored in T0 and T1
    t0_req = 1'b1;
    step(); chk("ign_t0", {2'b00, t_n}, 8'h3E);
    step(); chk("ign_t1", {2'b00, t_n}, 8'h3D);
    db = 8'h18;
    step(); chk("ign_t2", {2'b00, t_n}, 8'h3B);
    chk("ign_ir", ir, 8'h18);

`ifdef IR_INT_INJECT_EN
    // walk to T1, then injection with and without pending interrupt
    for (int pass = 0; pass < 2; pass++) begin
      t0_req = 1'b1;
      step();
      t0_req = 1'b0;
      step();
      db = 8'hEA; int_pending = (pass == 0);
      step();
      chk("inj_ir", ir, (pass == 0) ? 8'h00 : 8'hEA);
      chk("inj_ack", {7'd0, int_ack}, (pass == 0) ? 8'h01 : 8'h00);
      int_pending = 1'b0; db = 8'h00;
      step();
      chk("inj_ack_end", {7'd0, int_ack}, 8'h00);
    end
`endif

    // randomized run, checked against the model every cycle
    for (int n = 0; n < 3000; n++) begin
      reset  = ($urandom_range(0, 99) == 0);
      rdy    = ($urandom_range(0, 3) != 0);
      t0_req = $urandom_range(0, 1);
      db     = 8'($urandom);
`ifdef IR_INT_INJECT_EN
      int_pending = ($urandom_range(0, 2) == 0);
`endif
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
